// File: rtl/riscv_debug_pkg.sv
// Shared command/state encodings and trace-record layout for the riscv_i16 debug tracer.
// A record is packed {multi, idx, pc, value} with value in the low bits.
package riscv_debug_pkg;

    typedef enum logic [1:0] {
        CMD_HALT  = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_STEPPING = 2'b10
    } state_e;

    function automatic int rec_width(input int idx_w, input int pc_w, input int reg_w);
        return 1 + idx_w + pc_w + reg_w;
    endfunction

    function automatic int rec_pc_lsb(input int reg_w);
        return reg_w;
    endfunction

    function automatic int rec_idx_lsb(input int pc_w, input int reg_w);
        return reg_w + pc_w;
    endfunction

    function automatic int rec_multi_bit(input int idx_w, input int pc_w, input int reg_w);
        return reg_w + pc_w + idx_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO with flush. A push on a full FIFO is taken only
// when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/riscv_debug_tracer.sv
// Run-control (HALT/RUN/STEP-N) and register-write trace for the riscv_i16 core.
// Command handshake: a command is taken on any edge where CmdValid && CmdReady.
module riscv_debug_tracer
    import riscv_debug_pkg::*;
#(
    parameter int REG_WIDTH  = 16,
    parameter int NUM_REGS   = 8,
    parameter int PC_WIDTH   = 16,
    parameter int DEPTH      = 16,
    parameter int STEP_WIDTH = 16,
    localparam int IDX_W = $clog2(NUM_REGS),
    localparam int REC_W = rec_width(IDX_W, PC_WIDTH, REG_WIDTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_REGS*REG_WIDTH-1:0] DebugData,
    input  logic [PC_WIDTH-1:0]           PC,
    input  logic                          CmdValid,
    output logic                          CmdReady,
    input  logic [1:0]                    CmdOp,
    input  logic [STEP_WIDTH-1:0]         CmdCount,
    output logic                          CpuEnable,
    output logic                          Halted,
    output logic                          TraceValid,
    input  logic                          TraceReady,
    output logic [REC_W-1:0]              TraceData,
    output logic                          Overflow,
    output state_e                        DbgState,
    output logic [CNT_W-1:0]              DbgCount
);

    state_e                        state;
    logic [STEP_WIDTH-1:0]         step_cnt;
    logic                          cmd_fire;
    logic                          clear_fire;
    logic [NUM_REGS*REG_WIDTH-1:0] shadow;
    logic                          primed;
    logic [NUM_REGS-1:0]           mask;
    logic [IDX_W-1:0]              rec_idx;
    logic [REG_WIDTH-1:0]          rec_val;
    logic                          rec_multi;
    logic                          record;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          pop;
    logic                          push;

    assign cmd_fire   = CmdValid && CmdReady;
    assign clear_fire = cmd_fire && (CmdOp == CMD_CLEAR);
    assign DbgState   = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_HALTED;
            step_cnt  <= '0;
            CpuEnable <= 1'b0;
            Halted    <= 1'b1;
            CmdReady  <= 1'b1;
        end else begin
            case (state)
                ST_HALTED: begin
                    if (cmd_fire && CmdOp == CMD_RUN) begin
                        state     <= ST_RUNNING;
                        CpuEnable <= 1'b1;
                        Halted    <= 1'b0;
                    end else if (cmd_fire && CmdOp == CMD_STEP && CmdCount != '0) begin
                        state     <= ST_STEPPING;
                        step_cnt  <= CmdCount;
                        CpuEnable <= 1'b1;
                        Halted    <= 1'b0;
                        CmdReady  <= 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (cmd_fire && CmdOp == CMD_HALT) begin
                        state     <= ST_HALTED;
                        CpuEnable <= 1'b0;
                        Halted    <= 1'b1;
                    end
                end
                ST_STEPPING: begin
                    // The cycle that finishes the last enabled step drops CpuEnable.
                    if (step_cnt == STEP_WIDTH'(1)) begin
                        state     <= ST_HALTED;
                        step_cnt  <= '0;
                        CpuEnable <= 1'b0;
                        Halted    <= 1'b1;
                        CmdReady  <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_HALTED;
                    step_cnt  <= '0;
                    CpuEnable <= 1'b0;
                    Halted    <= 1'b1;
                    CmdReady  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        shadow <= DebugData;
        if (Reset) primed <= 1'b0;
        else       primed <= 1'b1;
    end

    // Lowest changed register wins; the loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        mask    = '0;
        rec_idx = '0;
        rec_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            mask[i] = primed && (DebugData[i*REG_WIDTH +: REG_WIDTH] != shadow[i*REG_WIDTH +: REG_WIDTH]);
        end
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                rec_idx = IDX_W'(i);
                rec_val = DebugData[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign rec_multi  = |(mask & (mask - 1'b1));
    assign record     = |mask;
    assign TraceValid = !fifo_empty;
    assign pop        = TraceValid && TraceReady;
    assign push       = record && !clear_fire;

    always_ff @(posedge Clk) begin
        if (Reset || clear_fire) Overflow <= 1'b0;
        else if (push && fifo_full && !pop) Overflow <= 1'b1;
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .reset (Reset),
        .flush (clear_fire),
        .push  (push),
        .pop   (pop),
        .wdata ({rec_multi, rec_idx, PC, rec_val}),
        .rdata (TraceData),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (DbgCount)
    );

endmodule

// File: tb/tb_riscv_debug_tracer.sv
// Randomized and directed bench for riscv_debug_tracer against a queue-based
// behavioural model of run-control and register-write tracing.
module tb_riscv_debug_tracer;

    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [127:0]  DebugData;
    logic [15:0]   PC;
    logic          CmdValid;
    logic          CmdReady;
    logic [1:0]    CmdOp;
    logic [15:0]   CmdCount;
    logic          CpuEnable;
    logic          Halted;
    logic          TraceValid;
    logic          TraceReady;
    logic [35:0]   TraceData;
    logic          Overflow;
    logic [1:0]    DbgState;
    logic [4:0]    DbgCount;

    logic [15:0]   regs [8];

    // Model: mode 0 halted, 1 running, 2 stepping.
    int            m_mode;
    int            m_steps;
    logic          m_ovf;
    logic          m_primed;
    logic [15:0]   m_prev [8];
    logic [35:0]   exp_q [$];

    int            n_checks = 0;
    int            n_pass = 0;

    riscv_debug_tracer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DebugData  (DebugData),
        .PC         (PC),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOp      (CmdOp),
        .CmdCount   (CmdCount),
        .CpuEnable  (CpuEnable),
        .Halted     (Halted),
        .TraceValid (TraceValid),
        .TraceReady (TraceReady),
        .TraceData  (TraceData),
        .Overflow   (Overflow),
        .DbgState   (DbgState),
        .DbgCount   (DbgCount)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        DebugData = '0;
        for (int i = 0; i < 8; i++) DebugData[i*16 +: 16] = regs[i];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_update();
        bit acc;
        int idx;
        int nchg;
        acc = CmdValid && (m_mode != 2);
        if (Reset) begin
            m_mode = 0;
            m_steps = 0;
            exp_q.delete();
            m_ovf = 1'b0;
            m_primed = 1'b0;
        end else begin
            nchg = 0;
            idx = 0;
            for (int i = 7; i >= 0; i--) begin
                if (regs[i] != m_prev[i]) begin
                    nchg++;
                    idx = i;
                end
            end
            if (acc && CmdOp == 2'd3) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (exp_q.size() > 0 && TraceReady) void'(exp_q.pop_front());
                if (m_primed && nchg > 0) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({nchg > 1, 3'(idx), PC, regs[idx]});
                    else m_ovf = 1'b1;
                end
            end
            if (m_mode == 2) begin
                m_steps--;
                if (m_steps == 0) m_mode = 0;
            end else if (acc) begin
                case (CmdOp)
                    2'd0: m_mode = 0;
                    2'd1: if (m_mode == 0) m_mode = 1;
                    2'd2: if (m_mode == 0 && CmdCount != 0) begin
                        m_mode = 2;
                        m_steps = CmdCount;
                    end
                    default: ;
                endcase
            end
            m_primed = 1'b1;
        end
        for (int i = 0; i < 8; i++) m_prev[i] = regs[i];
    endtask

    task automatic check_outputs();
        chk("cpu_enable", CpuEnable, m_mode != 0);
        chk("halted", Halted, m_mode == 0);
        chk("cmd_ready", CmdReady, m_mode != 2);
        chk("state", DbgState, m_mode);
        chk("trace_valid", TraceValid, exp_q.size() > 0);
        chk("fifo_count", DbgCount, exp_q.size());
        chk("overflow", Overflow, m_ovf);
        if (exp_q.size() > 0) chk("trace_data", TraceData, exp_q[0]);
    endtask

    task automatic cycle();
        model_update();
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] cnt);
        CmdValid = 1'b1;
        CmdOp = op;
        CmdCount = cnt;
        cycle();
        CmdValid = 1'b0;
    endtask

    initial begin
        int          n_en;
        logic [35:0] rec;
        Reset = 1'b1;
        PC = '0;
        CmdValid = 1'b0;
        CmdOp = '0;
        CmdCount = '0;
        TraceReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            regs[i] = '0;
            m_prev[i] = '0;
        end
        m_mode = 0;
        m_steps = 0;
        m_ovf = 1'b0;
        m_primed = 1'b0;

        // T1: reset held three cycles
        repeat (3) cycle();
        chk("t1_cpu_enable", CpuEnable, 1'b0);
        chk("t1_halted", Halted, 1'b1);
        chk("t1_trace_valid", TraceValid, 1'b0);
        chk("t1_overflow", Overflow, 1'b0);
        Reset = 1'b0;
        repeat (2) cycle();

        // T2: STEP 5 with reg1 0->7 at PC=2
        regs[1] = 16'd7;
        PC = 16'd2;
        send_cmd(2'd2, 16'd5);
        rec = {1'b0, 3'd1, 16'd2, 16'd7};
        chk("t2_record", TraceData, rec);
        n_en = int'(CpuEnable);
        repeat (7) begin
            cycle();
            n_en += int'(CpuEnable);
        end
        chk("t2_enabled_cycles", n_en, 5);
        chk("t2_halted", Halted, 1'b1);
        TraceReady = 1'b1;
        repeat (2) cycle();

        // T3: RUN, RUN ignored while running, HALT after 20 cycles
        send_cmd(2'd1, 16'd0);
        repeat (9) begin
            regs[$urandom_range(0, 7)] = 16'($urandom);
            PC = PC + 16'd1;
            cycle();
        end
        send_cmd(2'd1, 16'd0);
        chk("t3_still_running", CpuEnable, 1'b1);
        repeat (9) cycle();
        send_cmd(2'd0, 16'd0);
        chk("t3_halt_cpu_enable", CpuEnable, 1'b0);
        chk("t3_cmd_ready", CmdReady, 1'b1);
        repeat (3) cycle();

        // T4: two registers change in one cycle
        TraceReady = 1'b0;
        regs[2] = regs[2] + 16'd1;
        regs[5] = regs[5] + 16'd3;
        cycle();
        chk("t4_multi_idx", TraceData[35:32], 4'b1010);
        chk("t4_value", TraceData[15:0], regs[2]);

        // T5: overflow, pop+push at full, CLEAR racing a record
        TraceReady = 1'b1;
        repeat (2) cycle();
        TraceReady = 1'b0;
        for (int k = 0; k < 17; k++) begin
            regs[0] = regs[0] + 16'd1;
            PC = 16'(k);
            cycle();
        end
        chk("t5_overflow", Overflow, 1'b1);
        chk("t5_count_full", DbgCount, 5'd16);
        TraceReady = 1'b1;
        regs[3] = regs[3] + 16'd1;
        cycle();
        chk("t5_count_pop_push", DbgCount, 5'd16);
        TraceReady = 1'b0;
        regs[4] = regs[4] + 16'd1;
        send_cmd(2'd3, 16'd0);
        chk("t5_clear_overflow", Overflow, 1'b0);
        chk("t5_clear_valid", TraceValid, 1'b0);

        // T6: reset in the middle of STEP 100
        regs[7] = regs[7] + 16'd1;
        send_cmd(2'd2, 16'd100);
        regs[6] = regs[6] + 16'd1;
        repeat (60) cycle();
        chk("t6_stepping", CpuEnable, 1'b1);
        regs[1] = regs[1] + 16'd9;
        Reset = 1'b1;
        cycle();
        chk("t6_halted", Halted, 1'b1);
        chk("t6_fifo_empty", DbgCount, 5'd0);
        Reset = 1'b0;
        regs[6] = regs[6] + 16'd5;
        cycle();
        chk("t6_no_record", TraceValid, 1'b0);
        cycle();

        // Randomized traffic
        repeat (400) begin
            Reset = ($urandom_range(0, 99) == 0);
            CmdValid = ($urandom_range(0, 3) == 0);
            CmdOp = 2'($urandom_range(0, 3));
            CmdCount = 16'($urandom_range(0, 6));
            TraceReady = ($urandom_range(0, 2) != 0);
            PC = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                regs[$urandom_range(0, 7)] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
